// File: rtl/sudoku_ram_arbiter_if.sv
// rtl/sudoku_ram_arbiter_if.sv - req/gnt access bus between one requester and the RAM arbiter
interface sudoku_ram_arbiter_if;
  logic       req;
  logic       we;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       gnt;
  logic       rvalid;
  logic [7:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sudoku_ram_arbiter.sv
// rtl/sudoku_ram_arbiter.sv - two-port round-robin arbiter with bounded bursts for the result RAM
module sudoku_ram_arbiter #(
  parameter int CELLS     = 81,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  sudoku_ram_arbiter_if.slave m0,
  sudoku_ram_arbiter_if.slave m1,
  output logic                RAM_ceb,
  output logic                RAM_web,
  output logic [6:0]          RAM_A,
  output logic [7:0]          RAM_D,
  input  logic [7:0]          RAM_Q,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t     state;
  logic [3:0] cnt;
  logic       last;

  logic       grant;
  logic       sel;
  state_t     own_sel;
  logic       we_s;
  logic [6:0] addr_s;
  logic [7:0] wdata_s;
  logic       in_range;

  // Read return pipeline: stage 1 = RAM access cycle, stage 2 = RAM_Q cycle
  logic       rd_v1, rd_p1, rd_z1;
  logic       rd_v2, rd_p2, rd_z2;

  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    case (state)
      IDLE: begin
        if (m0.req && m1.req) begin
          grant = 1'b1;
          sel   = ~last;
        end else if (m0.req) begin
          grant = 1'b1;
        end else if (m1.req) begin
          grant = 1'b1;
          sel   = 1'b1;
        end
      end
      OWN0: begin
        if (m0.req && (!m1.req || cnt < BMAX)) begin
          grant = 1'b1;
        end else if (m1.req) begin
          grant = 1'b1;
          sel   = 1'b1;
        end
      end
      OWN1: begin
        if (m1.req && (!m0.req || cnt < BMAX)) begin
          grant = 1'b1;
          sel   = 1'b1;
        end else if (m0.req) begin
          grant = 1'b1;
        end
      end
      default: begin
        grant = 1'b0;
        sel   = 1'b0;
      end
    endcase
  end

  assign own_sel  = sel ? OWN1 : OWN0;
  assign we_s     = sel ? m1.we    : m0.we;
  assign addr_s   = sel ? m1.addr  : m0.addr;
  assign wdata_s  = sel ? m1.wdata : m0.wdata;
  assign in_range = ({1'b0, addr_s} < 8'(CELLS));

  // Grants are suppressed while reset is held so requesters never pop during reset
  assign m0.gnt = rst & grant & ~sel;
  assign m1.gnt = rst & grant & sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      RAM_ceb <= 1'b0;
      RAM_web <= 1'b1;
      RAM_A   <= 7'd0;
      RAM_D   <= 8'd0;
      err     <= 1'b0;
      rd_v1   <= 1'b0;
      rd_p1   <= 1'b0;
      rd_z1   <= 1'b0;
      rd_v2   <= 1'b0;
      rd_p2   <= 1'b0;
      rd_z2   <= 1'b0;
    end else begin
      rd_v2 <= rd_v1;
      rd_p2 <= rd_p1;
      rd_z2 <= rd_z1;
      rd_v1 <= grant & ~we_s;
      rd_p1 <= sel;
      rd_z1 <= ~in_range;
      if (grant) begin
        last  <= sel;
        state <= own_sel;
        if (state == own_sel)
          cnt <= (cnt < BMAX) ? cnt + 4'd1 : BMAX;
        else
          cnt <= 4'd1;
        // Out-of-range slots consume the grant but never touch the RAM
        RAM_ceb <= in_range;
        RAM_web <= ~(we_s & in_range);
        RAM_A   <= addr_s;
        RAM_D   <= we_s ? wdata_s : 8'd0;
        if (!in_range)
          err <= 1'b1;
      end else begin
        state   <= IDLE;
        cnt     <= 4'd0;
        RAM_ceb <= 1'b0;
        RAM_web <= 1'b1;
      end
    end
  end

  assign m0.rvalid = rd_v2 & ~rd_p2;
  assign m1.rvalid = rd_v2 & rd_p2;
  assign m0.rdata  = (rd_v2 & ~rd_p2 & ~rd_z2) ? RAM_Q : 8'd0;
  assign m1.rdata  = (rd_v2 & rd_p2 & ~rd_z2) ? RAM_Q : 8'd0;

endmodule

// File: doc/sudoku_ram_arbiter.md
Name: sudoku_ram_arbiter

Overview:
Arbitrates the single-port result RAM (81 cells, 8-bit, 7-bit address) between two requesters: port 0 is the solver/writer and port 1 is the readback/checker. Each port uses a req/gnt handshake. Accesses go to the RAM through registered outputs, and read data is routed back to the issuing port. Arbitration is round-robin with a bounded burst, and out-of-range addresses are blocked.

Parameters:
CELLS, 81, number of valid RAM cells; any address >= CELLS is out of range.
BURST_MAX, 4, maximum consecutive grants to one port while the other port is requesting (1..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
m0_req  in  1  port 0 access request; held with its qualifiers until m0_gnt
m0_we  in  1  port 0 access type: 1 = write, 0 = read
m0_addr  in  7  port 0 cell address
m0_wdata  in  8  port 0 write data
m0_gnt  out  1  port 0 request accepted this cycle
m0_rvalid  out  1  port 0 read data valid
m0_rdata  out  8  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to port 0, for port 1
RAM_ceb  out  1  RAM access enable, 1 = access this cycle
RAM_web  out  1  0 = write, 1 = read
RAM_A  out  7  RAM address
RAM_D  out  8  RAM write data
RAM_Q  in  8  RAM read data, valid the cycle after a read access
err  out  1  sticky flag: an out-of-range access has occurred

Behaviour:
- Reset (rst=0, asynchronous): RAM_ceb=0, RAM_web=1, RAM_A=0, RAM_D=0, err=0, all gnt/rvalid=0, rdata=0, state=IDLE, last-winner pointer=1 (so port 0 wins first), burst count=0. Any in-flight read is discarded; no rvalid follows reset release.
- Grant is combinational from req and the registered state; at most one gnt per cycle.
- A requester samples gnt at the clock edge and may change its request signals the cycle after gnt.
- State machine:
  - States: IDLE, OWN0, OWN1. Burst counter cnt is 4 bits.
  - IDLE, single requester: grant it; go to OWNx; cnt=1.
  - IDLE, both requesting: grant the port that is not the last winner.
  - OWNx, x requesting and (other idle or cnt<BURST_MAX): grant x; cnt+1, saturating at BURST_MAX.
  - OWNx, other requesting and (x idle or cnt==BURST_MAX): grant other; go to OWNother; cnt=1.
  - OWNx, neither port requesting: no grant; go to IDLE; cnt=0.
  - Last-winner pointer updates on every grant.
- Issue timing: grant in cycle T causes RAM_* to be registered at the T edge and driven during T+1.
  - Write: RAM_ceb=1, RAM_web=0, RAM_A=addr, RAM_D=wdata.
  - Read: RAM_ceb=1, RAM_web=1, RAM_A=addr, RAM_D=0.
  - No grant in T: RAM_ceb=0, RAM_web=1; RAM_A and RAM_D hold their previous values.
- Read return: the read issued during T+1 returns RAM_Q during T+2. The arbiter asserts rvalid to the issuing port at T+2 with rdata=RAM_Q, combinational from a registered valid/port tag.
  - Total read latency from gnt to rvalid: 2 cycles.
  - Back-to-back reads are fully pipelined: one per cycle, possibly alternating ports.
  - rdata of a non-returning port is 0.
- Out of range (addr >= CELLS):
  - The request is granted normally and counts toward the burst.
  - RAM_ceb stays 0 for that slot.
  - err is set on the grant edge and stays set until reset.
  - For a read, rvalid still pulses at T+2 with rdata=0.
- Write followed by a read of the same address on the next grant returns the new data, since the RAM is in order.
- req dropped without gnt is legal and causes no side effects.

Test Plan:
1. Reset: hold rst=0 with random inputs -> all outputs at reset values. Release rst; m0 and m1 both request reads -> m0_gnt in the first cycle.
2. Single write: m0 writes addr=5, data=0x37 in T -> m0_gnt=1 in T; during T+1, RAM_ceb=1, RAM_web=0, RAM_A=5, RAM_D=0x37.
3. Read latency: m1 reads addr=5 with the model RAM returning 0x37 -> m1_gnt at T, RAM read during T+1, m1_rvalid=1 and m1_rdata=0x37 at T+2; m0_rvalid stays 0 throughout.
4. Burst fairness: BURST_MAX=4, both ports requesting continuously for 16 cycles -> grant sequence 0000111100001111.
   - Then m1 drops req -> m0 is granted every cycle, with no switch forced.
5. Out of range: m0 reads addr=81 -> gnt given, RAM_ceb=0 in the issue slot, err=1 from the next cycle, m0_rvalid=1 with rdata=0 at T+2.
   - err stays 1 after a subsequent valid access.
6. Reset mid-read: m1 read granted at T; rst=0 during T+1 -> no m1_rvalid at T+2 or at any time after rst returns to 1; RAM_ceb=0.
